// File: rtl/lc3_mem_responder_pkg.sv
// Shared types and constants for the LC-3 memory/IO responder.
// The FSM state type, word width, default I/O address and a RAM-window decode helper.
package lc3_mem_pkg;

    localparam int unsigned WORD_W = 16;
    localparam logic [WORD_W-1:0] IO_SW_ADDR = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_state_t;

    // True when every address bit above the RAM index is clear.
    function automatic logic ram_mapped(input logic [WORD_W-1:0] addr,
                                        input int unsigned      addr_bits);
        return (addr >> addr_bits) == '0;
    endfunction

endpackage

// File: rtl/lc3_mem_responder_if.sv
// MAR/MDR memory port between the CPU datapath and the memory responder.
// Switches and the hex latch ride along because they share the I/O word.
interface lc3_mem_responder_if;

    logic                           Mem_Rd;
    logic                           Mem_Wr;
    logic [lc3_mem_pkg::WORD_W-1:0] MAR;
    logic [lc3_mem_pkg::WORD_W-1:0] MDR;
    logic [lc3_mem_pkg::WORD_W-1:0] Switches;
    logic [lc3_mem_pkg::WORD_W-1:0] MDR_In;
    logic                           R;
    logic [lc3_mem_pkg::WORD_W-1:0] HEX_Out;

    modport master (
        output Mem_Rd, Mem_Wr, MAR, MDR, Switches,
        input  MDR_In, R, HEX_Out
    );

    modport slave (
        input  Mem_Rd, Mem_Wr, MAR, MDR, Switches,
        output MDR_In, R, HEX_Out
    );

endinterface

// File: rtl/lc3_mem_responder_ram.sv
// Single-port word RAM: synchronous write, combinational read.
// Contents are never reset.
module lc3_ram_array
    import lc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory/IO responder on the CPU's MAR/MDR port: wait-state FSM, 4-phase R handshake,
// RAM window at the bottom of the address space and one switch/hex I/O word.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int unsigned       ADDR_BITS   = 8,
    parameter int unsigned       WAIT_STATES = 2,
    parameter logic [WORD_W-1:0] IO_ADDR     = IO_SW_ADDR
) (
    input logic                Clk,
    input logic                Reset,
    lc3_mem_responder_if.slave bus
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    mem_state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       latch;
    logic       access;
    logic       strobe;

    logic [WORD_W-1:0] addr_p0;
    logic [WORD_W-1:0] wdata_p0;
    logic              wr_p0;

    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_wr;
    logic              is_io;
    logic              is_ram;

    logic [WORD_W-1:0] mdr_in_q;
    logic [WORD_W-1:0] hex_q;

    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [WORD_W-1:0]    ram_rdata;

    assign strobe = bus.Mem_Rd | bus.Mem_Wr;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (strobe) begin
                    latch   = 1'b1;
                    cnt_nxt = WAIT_INIT;
                    if (WAIT_STATES == 0) begin
                        access    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                if (!strobe) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A zero-wait access completes on the sampling edge, so it must use the live bus.
    always_comb begin
        if (state == IDLE) begin
            acc_addr  = bus.MAR;
            acc_wdata = bus.MDR;
            acc_wr    = bus.Mem_Wr;
        end else begin
            acc_addr  = addr_p0;
            acc_wdata = wdata_p0;
            acc_wr    = wr_p0;
        end
    end

    assign is_io    = (acc_addr == IO_ADDR);
    assign is_ram   = ram_mapped(acc_addr, ADDR_BITS) && !is_io;
    assign ram_addr = acc_addr[ADDR_BITS-1:0];
    assign ram_we   = Reset && access && acc_wr && is_ram;

    lc3_ram_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk  (Clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(acc_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            mdr_in_q <= '0;
            hex_q    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (access && acc_wr && is_io) begin
                hex_q <= acc_wdata;
            end
            if (access && !acc_wr) begin
                mdr_in_q <= is_io ? bus.Switches : (is_ram ? ram_rdata : '0);
            end
        end
    end

    // Request capture: a write strobe wins when both strobes arrive together.
    always_ff @(posedge Clk) begin
        if (latch) begin
            addr_p0  <= bus.MAR;
            wdata_p0 <= bus.MDR;
            wr_p0    <= bus.Mem_Wr;
        end
    end

    always @(posedge Clk) begin
        if (Reset && state == IDLE) begin
            assert (!(bus.Mem_Rd && bus.Mem_Wr))
            else $warning("Mem_Rd and Mem_Wr both high at %h; treating as write", bus.MAR);
        end
    end

    assign bus.R       = (state == DONE);
    assign bus.MDR_In  = mdr_in_q;
    assign bus.HEX_Out = hex_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: directed scenarios plus randomized accesses
// checked against an address-map/array model.
module tb_lc3_mem_responder;

    localparam int W = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lc3_mem_responder_if bus();

    lc3_mem_responder #(
        .ADDR_BITS  (8),
        .WAIT_STATES(W),
        .IO_ADDR    (16'hFFFF)
    ) dut (
        .Clk  (clk),
        .Reset(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] mdr;
        logic [15:0] hex;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] ram_m [0:255];
    logic [15:0] mdr_m = 16'h0000;
    logic [15:0] hex_m = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: memory map rules applied to a plain array.
    function automatic void model(input bit rd, input bit wr, input logic [15:0] a,
                                  input logic [15:0] d, input logic [15:0] sw);
        if (wr) begin
            if (a == 16'hFFFF) hex_m = d;
            else if (a < 16'h0100) ram_m[a] = d;
        end else if (rd) begin
            if (a == 16'hFFFF) mdr_m = sw;
            else if (a < 16'h0100) mdr_m = ram_m[a];
            else mdr_m = 16'h0000;
        end
    endfunction

    // Monitor: every rising R must match the oldest outstanding expectation.
    initial begin
        logic r_prev;
        exp_t e;
        r_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.R && !r_prev) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_R: got R=1 expected no access in flight");
                end else begin
                    e = sb.pop_front();
                    check_int("latency", cyc, e.due);
                    check16("MDR_In", bus.MDR_In, e.mdr);
                    check16("HEX_Out", bus.HEX_Out, e.hex);
                end
            end
            r_prev = bus.R;
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                          input logic [15:0] d, input int hold, input bit early);
        exp_t e;
        int   t;
        @(negedge clk);
        bus.Mem_Rd = rd;
        bus.Mem_Wr = wr;
        bus.MAR    = a;
        bus.MDR    = d;
        model(rd, wr, a, d, bus.Switches);
        e.mdr = mdr_m;
        e.hex = hex_m;
        e.due = cyc + 1 + W + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.MAR = 16'($urandom);
        bus.MDR = 16'($urandom);
        if (early) begin
            bus.Mem_Rd = 1'b0;
            bus.Mem_Wr = 1'b0;
        end
        t = 0;
        while (!bus.R && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!bus.R) begin
            n_checks++;
            n_fail++;
            $display("FAIL R_timeout: got R=0 expected R=1 within 40 cycles");
        end
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check16("R_hold", {15'd0, bus.R}, 16'd1);
            end
            bus.Mem_Rd = 1'b0;
            bus.Mem_Wr = 1'b0;
        end
        @(negedge clk);
        check16("R_release", {15'd0, bus.R}, 16'd0);
    endtask

    task automatic reset_mid_access();
        @(negedge clk);
        bus.Mem_Wr = 1'b1;
        bus.MAR    = 16'h0020;
        bus.MDR    = 16'hCAFE;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check16("R_in_reset", {15'd0, bus.R}, 16'd0);
        @(negedge clk);
        check16("MDR_In_reset", bus.MDR_In, 16'h0000);
        check16("HEX_Out_reset", bus.HEX_Out, 16'h0000);
        bus.Mem_Wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdr_m = 16'h0000;
        hex_m = 16'h0000;
        @(negedge clk);
        check16("R_after_abort", {15'd0, bus.R}, 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a, d;
        bit          rd, wr;
        bus.Mem_Rd   = 1'b0;
        bus.Mem_Wr   = 1'b0;
        bus.MAR      = 16'h0000;
        bus.MDR      = 16'h0000;
        bus.Switches = 16'h0000;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check16("R_reset", {15'd0, bus.R}, 16'd0);
        check16("MDR_In_por", bus.MDR_In, 16'h0000);
        check16("HEX_Out_por", bus.HEX_Out, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check16("R_post_reset", {15'd0, bus.R}, 16'd0);

        for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 16'(i), 16'($urandom), 0, 1'b0);

        access(1'b0, 1'b1, 16'h0012, 16'hBEEF, 0, 1'b0);
        access(1'b1, 1'b0, 16'h0012, 16'h0000, 0, 1'b0);

        bus.Switches = 16'h1234;
        access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 1'b0);
        access(1'b0, 1'b1, 16'hFFFF, 16'h00A5, 0, 1'b0);

        access(1'b1, 1'b0, 16'h8000, 16'h0000, 0, 1'b0);
        access(1'b0, 1'b1, 16'h8000, 16'h5555, 0, 1'b0);
        access(1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0);

        access(1'b0, 1'b1, 16'h0020, 16'h1111, 0, 1'b0);
        reset_mid_access();
        access(1'b1, 1'b0, 16'h0020, 16'h0000, 0, 1'b0);

        access(1'b1, 1'b0, 16'h0012, 16'h0000, 5, 1'b0);
        access(1'b1, 1'b1, 16'h0030, 16'h7777, 0, 1'b0);
        access(1'b1, 1'b0, 16'h0030, 16'h0000, 0, 1'b0);
        access(1'b1, 1'b0, 16'h0005, 16'h0000, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    a = 16'hFFFF;
                2:       a = 16'h8000 | 16'($urandom & 32'h7FFE);
                default: a = 16'($urandom_range(0, 15));
            endcase
            d  = 16'($urandom);
            wr = ($urandom_range(0, 1) == 1);
            rd = !wr || ($urandom_range(0, 9) == 0);
            bus.Switches = 16'($urandom);
            access(rd, wr, a, d, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
        end

        repeat (5) @(negedge clk);
        check_int("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
